// File: rtl/mac_pkg.sv
// Shared definitions for the MAC row datapath and its partial-sum accumulator.
package mac_pkg;
  localparam int PSUM_BW = 16;
  localparam int ACT_BW  = 4;
  localparam int W_BW    = 4;

  typedef enum logic {
    ACC   = 1'b0,
    DRAIN = 1'b1
  } state_t;
endpackage

// File: rtl/psum_regfile.sv
// Per-channel running-sum storage: one write port, two asynchronous read ports
// (feedback to the MAC row and drain to the output stream).
module psum_regfile #(
  parameter int psum_bw = 16,
  parameter int num_oc  = 8,
  parameter int oc_w    = $clog2(num_oc)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               we,
  input  logic [oc_w-1:0]    waddr,
  input  logic [psum_bw-1:0] wdata,
  input  logic [oc_w-1:0]    fb_addr,
  output logic [psum_bw-1:0] fb_data,
  input  logic [oc_w-1:0]    dr_addr,
  output logic [psum_bw-1:0] dr_data
);

  logic [psum_bw-1:0] mem_r [num_oc];

  // Entry storage with asynchronous clear to zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < num_oc; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign fb_data = mem_r[fb_addr];
  assign dr_data = mem_r[dr_addr];

endmodule

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: feeds running sums back to the MAC row over a fixed
// tile schedule, then drains finished channel results with optional ReLU.
module psum_accumulator
  import mac_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int num_oc  = 8,
  parameter int k_tiles = 4,
  parameter int oc_w    = $clog2(num_oc)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               relu_en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [psum_bw-1:0] in_psum,
  output logic [psum_bw-1:0] psum_fb,
  output logic [oc_w-1:0]    cur_oc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [psum_bw-1:0] out_data,
  output logic [oc_w-1:0]    out_oc,
  output logic               busy
);

  localparam int tile_w = (k_tiles > 1) ? $clog2(k_tiles) : 1;
  localparam logic [oc_w-1:0]   OC_LAST   = oc_w'(num_oc - 1);
  localparam logic [tile_w-1:0] TILE_LAST = tile_w'(k_tiles - 1);

  state_t             state_r, state_nx_s;
  logic [tile_w-1:0]  tile_r, tile_nx_s;
  logic [oc_w-1:0]    oc_r, oc_nx_s;
  logic [oc_w-1:0]    drain_idx_r, drain_nx_s;
  logic               we_s;
  logic [psum_bw-1:0] fb_rd_s, dr_rd_s;

  psum_regfile #(
    .psum_bw (psum_bw),
    .num_oc  (num_oc),
    .oc_w    (oc_w)
  ) u_regfile (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (we_s),
    .waddr   (oc_r),
    .wdata   (in_psum),
    .fb_addr (oc_r),
    .fb_data (fb_rd_s),
    .dr_addr (drain_idx_r),
    .dr_data (dr_rd_s)
  );

  // Next-state, counter and write-enable logic; clear overrides everything
  always_comb begin
    state_nx_s = state_r;
    tile_nx_s  = tile_r;
    oc_nx_s    = oc_r;
    drain_nx_s = drain_idx_r;
    we_s       = 1'b0;
    if (clear) begin
      state_nx_s = ACC;
      tile_nx_s  = '0;
      oc_nx_s    = '0;
      drain_nx_s = '0;
    end else begin
      case (state_r)
        ACC: begin
          if (in_valid) begin
            we_s = 1'b1;
            if (oc_r == OC_LAST) begin
              oc_nx_s = '0;
              if (tile_r == TILE_LAST) begin
                tile_nx_s  = '0;
                state_nx_s = DRAIN;
              end else begin
                tile_nx_s = tile_r + tile_w'(1);
              end
            end else begin
              oc_nx_s = oc_r + oc_w'(1);
            end
          end else begin
            we_s = 1'b0;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (drain_idx_r == OC_LAST) begin
              drain_nx_s = '0;
              state_nx_s = ACC;
            end else begin
              drain_nx_s = drain_idx_r + oc_w'(1);
            end
          end else begin
            drain_nx_s = drain_idx_r;
          end
        end
        default: begin
          state_nx_s = ACC;
          tile_nx_s  = '0;
          oc_nx_s    = '0;
          drain_nx_s = '0;
        end
      endcase
    end
  end

  // FSM and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ACC;
      tile_r      <= '0;
      oc_r        <= '0;
      drain_idx_r <= '0;
    end else begin
      state_r     <= state_nx_s;
      tile_r      <= tile_nx_s;
      oc_r        <= oc_nx_s;
      drain_idx_r <= drain_nx_s;
    end
  end

  // Tile 0 starts from zero so stale entries of the previous pass are ignored
  always_comb begin
    psum_fb  = '0;
    out_data = '0;
    if (state_r == ACC) begin
      psum_fb  = (tile_r == '0) ? '0 : fb_rd_s;
      out_data = '0;
    end else begin
      psum_fb  = '0;
      out_data = (relu_en && dr_rd_s[psum_bw-1]) ? '0 : dr_rd_s;
    end
  end

  assign in_ready  = (state_r == ACC);
  assign out_valid = (state_r == DRAIN);
  assign cur_oc    = oc_r;
  assign out_oc    = drain_idx_r;
  assign busy      = (tile_r != '0) || (oc_r != '0) || (state_r == DRAIN);

endmodule
